// File: rtl/raise_frame_sched.sv
// raise_frame_sched: grants whole frames from two FFT bin sources (s0, s1)
// to a single frequency-raise datapath. Round-robin arbitration happens per
// frame, bins are forwarded through one register stage, and the scheduler
// holds both sources off until the datapath reports frame completion.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | no frame owned; arbitrate between pending sources
//   ST_STREAM | granted source owns the datapath; bins forwarded 1:1
//   ST_WAIT   | last bin sent; waiting for m_done or the completion timeout
module raise_frame_sched #(
  parameter int DW        = 32,
  parameter int FW        = 6,
  parameter int FRAME_LEN = 64,
  parameter int DONE_TO   = 255
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_s0_valid,
  input  logic [DW-1:0] i_s0_data,
  input  logic [FW-1:0] i_s0_freq,
  input  logic          i_s0_fin,
  output logic          o_s0_ready,
  input  logic          i_s1_valid,
  input  logic [DW-1:0] i_s1_data,
  input  logic [FW-1:0] i_s1_freq,
  input  logic          i_s1_fin,
  output logic          o_s1_ready,
  output logic          o_m_valid,
  output logic [DW-1:0] o_m_data,
  output logic [FW-1:0] o_m_freq,
  output logic          o_m_fin,
  output logic          o_m_src,
  input  logic          i_m_done,
  output logic          o_busy,
  output logic          o_err_len,
  output logic          o_err_to,
  output logic [7:0]    o_frame_cnt
);

  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] LAST_BIN = CW'(FRAME_LEN - 1);
  localparam logic [7:0]    TO_LAST  = 8'(DONE_TO - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  state_t        r_state,     w_nxt_state;
  logic          r_grant,     w_nxt_grant;
  logic          r_rr,        w_nxt_rr;
  logic [CW-1:0] r_bin_cnt,   w_nxt_bin_cnt;
  logic [7:0]    r_to_cnt,    w_nxt_to_cnt;
  logic          r_m_valid,   w_nxt_m_valid;
  logic [DW-1:0] r_m_data,    w_nxt_m_data;
  logic [FW-1:0] r_m_freq,    w_nxt_m_freq;
  logic          r_m_fin,     w_nxt_m_fin;
  logic          r_err_len,   w_nxt_err_len;
  logic          r_err_to,    w_nxt_err_to;
  logic [7:0]    r_frame_cnt, w_nxt_frame_cnt;

  logic          w_sel_valid;
  logic [DW-1:0] w_sel_data;
  logic [FW-1:0] w_sel_freq;
  logic          w_sel_fin;
  logic          w_last_bin;
  logic          w_streaming;

  // Granted-source mux; ready depends only on registered state and grant
  always_comb begin
    w_streaming = (r_state == ST_STREAM);
    w_sel_valid = r_grant ? i_s1_valid : i_s0_valid;
    w_sel_data  = r_grant ? i_s1_data  : i_s0_data;
    w_sel_freq  = r_grant ? i_s1_freq  : i_s0_freq;
    w_sel_fin   = r_grant ? i_s1_fin   : i_s0_fin;
    w_last_bin  = (r_bin_cnt == LAST_BIN);
    o_s0_ready  = w_streaming && !r_grant;
    o_s1_ready  = w_streaming &&  r_grant;
  end

  // Next-state, arbitration, forwarding and error bookkeeping
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_grant     = r_grant;
    w_nxt_rr        = r_rr;
    w_nxt_bin_cnt   = r_bin_cnt;
    w_nxt_to_cnt    = r_to_cnt;
    w_nxt_m_valid   = 1'b0;
    w_nxt_m_data    = r_m_data;
    w_nxt_m_freq    = r_m_freq;
    w_nxt_m_fin     = 1'b0;
    w_nxt_err_len   = r_err_len;
    w_nxt_err_to    = r_err_to;
    w_nxt_frame_cnt = r_frame_cnt;

    case (r_state)
      ST_IDLE: begin
        w_nxt_bin_cnt = '0;
        w_nxt_to_cnt  = '0;
        if (i_s0_valid && i_s1_valid) begin
          w_nxt_grant = r_rr;
          w_nxt_state = ST_STREAM;
        end else if (i_s0_valid) begin
          w_nxt_grant = 1'b0;
          w_nxt_state = ST_STREAM;
        end else if (i_s1_valid) begin
          w_nxt_grant = 1'b1;
          w_nxt_state = ST_STREAM;
        end
      end

      ST_STREAM: begin
        if (w_sel_valid) begin
          w_nxt_m_valid = 1'b1;
          w_nxt_m_data  = w_sel_data;
          w_nxt_m_freq  = w_sel_freq;
          // A frame that runs to FRAME_LEN without fin is cut off here
          w_nxt_m_fin   = w_sel_fin || w_last_bin;
          w_nxt_bin_cnt = r_bin_cnt + 1'b1;
          if (w_sel_fin || w_last_bin) begin
            w_nxt_state   = ST_WAIT;
            w_nxt_bin_cnt = '0;
            w_nxt_to_cnt  = '0;
            if (w_sel_fin != w_last_bin) begin
              w_nxt_err_len = 1'b1;
            end
          end
        end
      end

      ST_WAIT: begin
        if (i_m_done) begin
          w_nxt_frame_cnt = r_frame_cnt + 8'd1;
          w_nxt_rr        = ~r_grant;
          w_nxt_state     = ST_IDLE;
          w_nxt_bin_cnt   = '0;
          w_nxt_to_cnt    = '0;
        end else if (r_to_cnt == TO_LAST) begin
          // DONE_TO wait cycles elapsed: give up on this frame
          w_nxt_err_to  = 1'b1;
          w_nxt_rr      = ~r_grant;
          w_nxt_state   = ST_IDLE;
          w_nxt_bin_cnt = '0;
          w_nxt_to_cnt  = '0;
        end else begin
          w_nxt_to_cnt = r_to_cnt + 8'd1;
        end
      end

      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any frame in flight
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_grant     <= 1'b0;
      r_rr        <= 1'b0;
      r_bin_cnt   <= '0;
      r_to_cnt    <= '0;
      r_m_valid   <= 1'b0;
      r_m_data    <= '0;
      r_m_freq    <= '0;
      r_m_fin     <= 1'b0;
      r_err_len   <= 1'b0;
      r_err_to    <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_grant     <= w_nxt_grant;
      r_rr        <= w_nxt_rr;
      r_bin_cnt   <= w_nxt_bin_cnt;
      r_to_cnt    <= w_nxt_to_cnt;
      r_m_valid   <= w_nxt_m_valid;
      r_m_data    <= w_nxt_m_data;
      r_m_freq    <= w_nxt_m_freq;
      r_m_fin     <= w_nxt_m_fin;
      r_err_len   <= w_nxt_err_len;
      r_err_to    <= w_nxt_err_to;
      r_frame_cnt <= w_nxt_frame_cnt;
    end
  end

  // Registered outputs
  always_comb begin
    o_m_valid   = r_m_valid;
    o_m_data    = r_m_data;
    o_m_freq    = r_m_freq;
    o_m_fin     = r_m_fin;
    o_m_src     = r_grant;
    o_busy      = (r_state != ST_IDLE);
    o_err_len   = r_err_len;
    o_err_to    = r_err_to;
    o_frame_cnt = r_frame_cnt;
  end

endmodule

// File: tb/tb_raise_frame_sched.sv
// Bench for raise_frame_sched: a table of frame scenarios, each run through
// one cycle-driven loop, with a scoreboard of the bins actually handed over.
module tb_raise_frame_sched;

  localparam int DW        = 32;
  localparam int FW        = 6;
  localparam int FRAME_LEN = 64;
  localparam int DONE_TO   = 255;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s0_valid, s1_valid, s0_fin, s1_fin;
  logic [DW-1:0] s0_data, s1_data;
  logic [FW-1:0] s0_freq, s1_freq;
  logic          s0_ready, s1_ready;
  logic          m_valid, m_fin, m_src, m_done;
  logic [DW-1:0] m_data;
  logic [FW-1:0] m_freq;
  logic          busy, err_len, err_to;
  logic [7:0]    frame_cnt;

  int total = 0;
  int bad   = 0;

  raise_frame_sched #(
    .DW(DW), .FW(FW), .FRAME_LEN(FRAME_LEN), .DONE_TO(DONE_TO)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_s0_valid(s0_valid), .i_s0_data(s0_data), .i_s0_freq(s0_freq),
    .i_s0_fin(s0_fin), .o_s0_ready(s0_ready),
    .i_s1_valid(s1_valid), .i_s1_data(s1_data), .i_s1_freq(s1_freq),
    .i_s1_fin(s1_fin), .o_s1_ready(s1_ready),
    .o_m_valid(m_valid), .o_m_data(m_data), .o_m_freq(m_freq),
    .o_m_fin(m_fin), .o_m_src(m_src), .i_m_done(m_done),
    .o_busy(busy), .o_err_len(err_len), .o_err_to(err_to),
    .o_frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // pre: 0 none, 1 reset first, 2 reset then abort a frame mid-stream first
  // mask bit0 = s0 offers a frame, bit1 = s1; fin_at -1 = never; dly -1 = no m_done
  typedef struct {
    int         pre;
    logic [1:0] mask;
    int         nbins;
    int         fin_at;
    int         dly;
    int         e_src;
    int         e_beats;
    int         e_fin;
    int         e_len;
    int         e_to;
    int         e_fcnt;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int s, input int k);
    return (s != 0 ? 32'hA500_0000 : 32'h5A00_0000) | DW'(k);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; m_done = 1'b0;
    s0_valid = 1'b0; s1_valid = 1'b0; s0_fin = 1'b0; s1_fin = 1'b0;
    s0_data = '0; s1_data = '0; s0_freq = '0; s1_freq = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'(|{s0_ready, s1_ready, m_valid, m_data, m_freq, m_fin,
        m_src, busy, err_len, err_to, frame_cnt}), 0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic abort_mid_stream();
    int idx;
    idx = 0;
    for (int c = 0; c < 100 && idx < 20; c++) begin
      @(negedge clk);
      if (idx < 20) begin
        s0_valid = 1'b1; s0_data = pat(0, idx); s0_freq = FW'(idx); s0_fin = 1'b0;
        if (s0_ready) idx++;
      end
    end
    @(negedge clk);
    chk("pre_reset_busy", int'(busy), 1);
    s0_data = pat(0, 20); s0_freq = FW'(20);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", int'(|{s0_ready, s1_ready, m_valid, m_data, m_freq, m_fin,
        m_src, busy, err_len, err_to, frame_cnt}), 0);
    s0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_case(input int vi, input vec_t v);
    logic [DW+FW-1:0] q[$];
    logic [DW+FW-1:0] exp_bin;
    int idx[2];
    int n_sent, beats, fin_beat, fin_cnt, fin_err, data_err, other_bad;
    int src, wait_ctr;
    bit frame_over, fin_seen, done_sent, finished, a0, a1, x0, x1, end0, end1;
    idx[0] = 0; idx[1] = 0;
    n_sent = 0; beats = 0; fin_beat = 0; fin_cnt = 0; fin_err = 0;
    data_err = 0; other_bad = 0; src = -1; wait_ctr = 0;
    frame_over = 0; fin_seen = 0; done_sent = 0; finished = 0;
    for (int cyc = 0; cyc < 700 && !finished; cyc++) begin
      @(negedge clk);
      if (done_sent) begin
        chk($sformatf("v%0d_busy_after_done", vi), int'(busy), 0);
        finished = 1;
      end else if (fin_seen && !busy) begin
        finished = 1;
      end
      if (m_valid) begin
        beats++;
        if (beats == 1) src = int'(m_src);
        if (q.size() == 0) data_err++;
        else begin
          exp_bin = q.pop_front();
          if ({m_data, m_freq} != exp_bin) data_err++;
        end
        if (m_fin != (beats == v.e_fin)) fin_err++;
        if (m_fin) begin
          fin_beat = beats; fin_cnt++;
          if (!fin_seen) begin
            fin_seen = 1; wait_ctr = 0;
            chk($sformatf("v%0d_busy_in_wait", vi), int'(busy), 1);
            chk($sformatf("v%0d_ready_after_fin", vi), int'(s0_ready | s1_ready), 0);
          end
        end
      end
      if ((v.e_src == 0 && s1_ready) || (v.e_src == 1 && s0_ready)) other_bad++;
      m_done = 1'b0;
      if (fin_seen && !done_sent && !finished) begin
        if (v.dly >= 0 && wait_ctr == v.dly) begin
          m_done = 1'b1; done_sent = 1;
        end
        if (v.dly < 0 && wait_ctr == 250)
          chk($sformatf("v%0d_no_early_timeout", vi), int'({busy, err_to}), 2);
        wait_ctr++;
      end
      a0 = v.mask[0] && idx[0] < v.nbins && !frame_over && !finished;
      a1 = v.mask[1] && idx[1] < v.nbins && !frame_over && !finished;
      s0_valid = a0; s0_data = pat(0, idx[0]); s0_freq = FW'(idx[0]);
      s0_fin = (idx[0] == v.fin_at);
      s1_valid = a1; s1_data = pat(1, idx[1]); s1_freq = FW'(idx[1]);
      s1_fin = (idx[1] == v.fin_at);
      x0 = a0 && s0_ready;
      x1 = a1 && s1_ready;
      end0 = 0; end1 = 0;
      if (x0) begin
        q.push_back({s0_data, s0_freq});
        n_sent++;
        end0 = (idx[0] == v.fin_at) || (n_sent == FRAME_LEN);
        idx[0]++;
      end
      if (x1) begin
        q.push_back({s1_data, s1_freq});
        n_sent++;
        end1 = (idx[1] == v.fin_at) || (n_sent == FRAME_LEN);
        idx[1]++;
      end
      if (end0 || end1) frame_over = 1;
    end
    m_done = 1'b0; s0_valid = 1'b0; s1_valid = 1'b0;
    if (!finished) chk($sformatf("v%0d_frame_timeout", vi), 0, 1);
    chk($sformatf("v%0d_src", vi), src, v.e_src);
    chk($sformatf("v%0d_beats", vi), beats, v.e_beats);
    chk($sformatf("v%0d_fin_beat", vi), fin_beat, v.e_fin);
    chk($sformatf("v%0d_fin_count", vi), fin_cnt, 1);
    chk($sformatf("v%0d_fin_pos_err", vi), fin_err, 0);
    chk($sformatf("v%0d_data_err", vi), data_err, 0);
    chk($sformatf("v%0d_other_ready", vi), other_bad, 0);
    chk($sformatf("v%0d_err_len", vi), int'(err_len), v.e_len);
    chk($sformatf("v%0d_err_to", vi), int'(err_to), v.e_to);
    chk($sformatf("v%0d_frame_cnt", vi), int'(frame_cnt), v.e_fcnt);
  endtask

  initial begin
    //           pre mask   nb  fin dly src beats fin len to fcnt
    vecs[0] = '{1, 2'b01, 64, 63,  3, 0, 64, 64, 0, 0, 1};
    vecs[1] = '{1, 2'b11, 64, 63,  0, 0, 64, 64, 0, 0, 1};
    vecs[2] = '{0, 2'b11, 64, 63,  5, 1, 64, 64, 0, 0, 2};
    vecs[3] = '{0, 2'b11, 64, 63,  0, 0, 64, 64, 0, 0, 3};
    vecs[4] = '{0, 2'b11, 64, 63,  5, 1, 64, 64, 0, 0, 4};
    vecs[5] = '{1, 2'b10, 11, 10,  4, 1, 11, 11, 1, 0, 1};
    vecs[6] = '{1, 2'b01, 70, -1,  2, 0, 64, 64, 1, 0, 1};
    vecs[7] = '{1, 2'b01, 64, 63, -1, 0, 64, 64, 0, 1, 0};
    vecs[8] = '{0, 2'b11, 64, 63,  2, 1, 64, 64, 0, 1, 1};
    vecs[9] = '{2, 2'b01, 64, 63,  3, 0, 64, 64, 0, 0, 1};

    rst_n = 1'b0; m_done = 1'b0;
    s0_valid = 1'b0; s1_valid = 1'b0; s0_fin = 1'b0; s1_fin = 1'b0;
    s0_data = '0; s1_data = '0; s0_freq = '0; s1_freq = '0;

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].pre != 0) do_reset();
      if (vecs[i].pre == 2) abort_mid_stream();
      run_case(i, vecs[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/raise_frame_sched.md
Name: raise_frame_sched

Overview:
- Frame-level scheduler that shares one frequency-raise datapath between two FFT bin sources (s0, s1).
- Grants a whole frame to one source using round-robin, then forwards its bins as a registered stream.
- Holds off both sources until the datapath signals frame completion.
- Enforces frame length and a completion timeout, and sits between the two FFT stages and the raise datapath.

Parameters:
- DW, 32, width of one FFT bin word.
- FW, 6, width of the bin index field.
- FRAME_LEN, 64, bins per frame.
- DONE_TO, 255, maximum WAIT cycles to wait for m_done (8-bit counter).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- s0_valid / s1_valid  in  1  source has a bin available.
- s0_data / s1_data  in  DW  bin value.
- s0_freq / s1_freq  in  FW  bin index.
- s0_fin / s1_fin  in  1  last bin of the frame.
- s0_ready / s1_ready  out  1  scheduler accepts a bin this cycle.
- m_valid  out  1  bin presented to the datapath.
- m_data  out  DW  forwarded bin value.
- m_freq  out  FW  forwarded bin index.
- m_fin  out  1  last bin of the frame to the datapath.
- m_src  out  1  source of the current frame (0 = s0, 1 = s1).
- m_done  in  1  datapath frame-complete pulse.
- busy  out  1  state is not IDLE.
- err_len  out  1  sticky frame-length error.
- err_to  out  1  sticky completion-timeout error.
- frame_cnt  out  8  completed frames, wraps 255 -> 0.

Behaviour:
Reset (rst low, asynchronous):
- All outputs 0; state IDLE; rr pointer 0 (s0 preferred); bin counter and timeout counter 0.
- Reset mid-frame abandons the frame immediately, with no m_fin emitted.

States:
- IDLE:
  - s*_ready = 0.
  - If exactly one s*_valid is high, latch that source as the grant.
  - If both are high, grant the source equal to the rr pointer.
  - On a grant go to STREAM; m_src updates on the same edge.
- STREAM:
  - Only the granted source's ready = 1; the other is 0.
  - A transfer occurs when valid and ready are both high.
  - Each transfer registers data/freq/fin into m_* with m_valid = 1 on the next cycle (1-cycle latency) and increments the bin counter.
  - A stall (valid low) yields m_valid = 0; there is no timeout in STREAM.
- End of frame, on the transfer where fin = 1 or the bin counter = FRAME_LEN-1:
  - m_fin = 1 on that beat; go to WAIT.
  - fin = 1 with count != FRAME_LEN-1 (short frame): set err_len.
  - count = FRAME_LEN-1 with fin = 0 (long frame): force m_fin = 1 and set err_len.
- WAIT:
  - Both readys 0; the timeout counter increments each cycle.
  - m_done high in any WAIT cycle, including the first: frame_cnt++, rr pointer = ~m_src, go to IDLE, clear counters.
  - Timeout counter reaches DONE_TO without m_done: set err_to, rr pointer = ~m_src, go to IDLE; frame_cnt is not incremented.
- m_done outside WAIT is ignored.
- err_len and err_to clear only on reset.
- Minimum turnaround: m_done cycle -> IDLE -> grant -> first transfer, so at least 2 idle cycles between frames.
- No combinational path from s*_valid to m_*; s*_ready is decoded from registered state and grant only.

Test Plan:
1. s0 sends a 64-bin frame (fin on bin 63) and m_done is pulsed 3 cycles after m_fin -> 64 m_valid beats with m_src = 0, m_fin only on beat 64, frame_cnt = 1, no errors, busy falls the cycle after m_done.
2. s0_valid and s1_valid held high, 4 frames with m_done returned each time -> grant order 0,1,0,1 and frame_cnt = 4; the non-granted ready stays 0 throughout.
3. s1 asserts fin on bin 10 -> m_fin on beat 11, err_len = 1, state WAIT; a later m_done still increments frame_cnt.
4. s0 sends 70 bins with no fin -> m_fin forced on beat 64, ready drops after beat 64, err_len = 1.
5. m_done withheld after a frame -> err_to = 1 after 255 WAIT cycles, return to IDLE, next grant goes to the other source, frame_cnt unchanged.
6. rst pulsed low mid-STREAM at bin 20 -> all outputs 0 immediately; after release a fresh s0 frame of 64 bins completes cleanly with frame_cnt = 1.
